// File: rtl/rock_strategy_ctrl.sv
// rock_strategy_ctrl: picks a rocking speed from the stress level trend.
// Starts rocking when stress reaches START_LEVEL, re-evaluates every
// EVAL_CYCLES clocks and stops after CALM_WINDOWS calm evaluations.
// Optional macro ROCK_ALARM_EN adds a sticky "rocking not helping" alarm.
module rock_strategy_ctrl #(
    parameter int EVAL_CYCLES  = 1000,
    parameter int SPEED_MAX    = 7,
    parameter int SPEED_INIT   = 3,
    parameter int START_LEVEL  = 3,
    parameter int CALM_WINDOWS = 4,
    parameter int MAX_TRIES    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] status,
    input  logic       gedaald,
    input  logic       gelijk,
    output logic [2:0] speed,
    output logic       direction,
    output logic       rocking,
    output logic       eval_tick,
    output logic       alarm
);

    localparam int WIN_W  = $clog2(EVAL_CYCLES);
    localparam int CALM_W = $clog2(CALM_WINDOWS + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(EVAL_CYCLES - 1);
    localparam logic [CALM_W-1:0] CALM_LAST = CALM_W'(CALM_WINDOWS - 1);
    localparam logic [2:0]        SMAX      = 3'(SPEED_MAX);
    localparam logic [2:0]        SINIT     = 3'(SPEED_INIT);
    localparam logic [2:0]        START_L   = 3'(START_LEVEL);

    // Elaboration-time parameter sanity checks
    if (EVAL_CYCLES < 2 || SPEED_MAX < 1 || SPEED_MAX > 7 ||
        SPEED_INIT < 1 || SPEED_INIT > SPEED_MAX ||
        START_LEVEL < 0 || START_LEVEL > 7 ||
        CALM_WINDOWS < 1 || MAX_TRIES < 1) begin : g_bad_params
        $error("rock_strategy_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EVAL
    } state_t;

    state_t              state_q, state_d;
    logic [WIN_W-1:0]    win_q,   win_d;
    logic [CALM_W-1:0]   calm_q,  calm_d;
    logic [2:0]          speed_q, speed_d;
    logic                dir_q,   dir_d;
    logic                rock_q,  rock_d;
    logic                tick_q,  tick_d;

`ifdef ROCK_ALARM_EN
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);

    logic [TRY_W-1:0]    tries_q, tries_d;
    logic                alarm_q, alarm_d;
`endif

    // One speed step in direction 'up', reflecting off 1 and SPEED_MAX.
    // Returns {new_direction, new_speed}.
    function automatic logic [3:0] step(input logic [2:0] s, input logic up);
        logic [3:0] r;
        if (up) begin
            if (s == SMAX) r = {1'b0, s - 3'd1};
            else           r = {1'b1, s + 3'd1};
        end else begin
            if (s == 3'd1) r = {1'b1, 3'd2};
            else           r = {1'b0, s - 3'd1};
        end
        return r;
    endfunction

    // State and output registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= '0;
            calm_q  <= '0;
            speed_q <= '0;
            dir_q   <= 1'b1;
            rock_q  <= 1'b0;
            tick_q  <= 1'b0;
`ifdef ROCK_ALARM_EN
            tries_q <= '0;
            alarm_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            calm_q  <= calm_d;
            speed_q <= speed_d;
            dir_q   <= dir_d;
            rock_q  <= rock_d;
            tick_q  <= tick_d;
`ifdef ROCK_ALARM_EN
            tries_q <= tries_d;
            alarm_q <= alarm_d;
`endif
        end
    end

    // Next-state, window timing and evaluation decision
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        calm_d  = calm_q;
        speed_d = speed_q;
        dir_d   = dir_q;
        rock_d  = rock_q;
        tick_d  = 1'b0;
`ifdef ROCK_ALARM_EN
        tries_d = tries_q;
        alarm_d = alarm_q;
`endif
        case (state_q)
            IDLE: begin
                win_d   = '0;
                calm_d  = '0;
                speed_d = '0;
                rock_d  = 1'b0;
                if (status >= START_L) begin
                    state_d = RUN;
                    speed_d = SINIT;
                    dir_d   = 1'b1;
                    rock_d  = 1'b1;
                end
            end
            RUN: begin
                if (win_q == WIN_LAST) begin
                    win_d   = '0;
                    state_d = EVAL;
                    tick_d  = 1'b1;
                end else begin
                    win_d = win_q + 1'b1;
                end
            end
            EVAL: begin
                state_d = RUN;
                if (status == 3'd0) begin
                    if (calm_q == CALM_LAST) begin
                        state_d = IDLE;
                        calm_d  = '0;
                        speed_d = '0;
                        rock_d  = 1'b0;
                    end else begin
                        calm_d = calm_q + 1'b1;
                    end
                end else begin
                    calm_d = '0;
                    // Level: keep going the same way; rising: reverse.
                    if (!gedaald) begin
                        {dir_d, speed_d} = step(speed_q, gelijk ? dir_q : ~dir_q);
                    end
                end
`ifdef ROCK_ALARM_EN
                if (status == 3'd0 || gedaald) begin
                    tries_d = '0;
                    if (status == 3'd0) alarm_d = 1'b0;
                end else if (tries_q != TRY_MAX) begin
                    tries_d = tries_q + 1'b1;
                    if (tries_q + 1'b1 == TRY_MAX) alarm_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign speed     = speed_q;
    assign direction = dir_q;
    assign rocking   = rock_q;
    assign eval_tick = tick_q;
`ifdef ROCK_ALARM_EN
    assign alarm     = alarm_q;
`else
    assign alarm     = 1'b0;
`endif

endmodule

// File: tb/tb_rock_strategy_ctrl.sv
// Scoreboard bench for rock_strategy_ctrl: a window-level behavioural
// model predicts outputs per cycle; a monitor compares them.
module tb_rock_strategy_ctrl;

    localparam int EC = 4;   // evaluation window length
    localparam int SM = 7;   // max speed
    localparam int SI = 3;   // initial speed
    localparam int CW = 2;   // calm windows
    localparam int MT = 3;   // max tries
    localparam int SL = 3;   // start level

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] status = '0;
    logic       gedaald = 1'b0;
    logic       gelijk = 1'b0;
    logic [2:0] speed;
    logic       direction, rocking, eval_tick, alarm;

    rock_strategy_ctrl #(
        .EVAL_CYCLES (EC),
        .SPEED_MAX   (SM),
        .SPEED_INIT  (SI),
        .START_LEVEL (SL),
        .CALM_WINDOWS(CW),
        .MAX_TRIES   (MT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .status    (status),
        .gedaald   (gedaald),
        .gelijk    (gelijk),
        .speed     (speed),
        .direction (direction),
        .rocking   (rocking),
        .eval_tick (eval_tick),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int spd;
        int dir;
        int rock;
        int tick;
        int alm;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // Behavioural model: phase 0..EC-1 are run cycles, phase EC is the evaluation cycle
    int m_active = 0, m_phase = 0, m_spd = 0, m_dir = 1;
    int m_calm = 0, m_tries = 0, m_alarm = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic m_step(input int up);
        m_dir = up;
        m_spd = m_spd + (up != 0 ? 1 : -1);
        if (m_spd > SM) begin m_spd = SM - 1; m_dir = 0; end
        if (m_spd < 1)  begin m_spd = 2;      m_dir = 1; end
    endtask

    task automatic m_eval(input int st, input int ged, input int gel);
        if (st == 0) begin
            m_calm++;
            m_tries = 0;
            m_alarm = 0;
            if (m_calm >= CW) begin
                m_active = 0;
                m_spd = 0;
                m_calm = 0;
            end
        end else begin
            m_calm = 0;
            if (ged != 0) begin
                m_tries = 0;
            end else begin
                if (m_tries < MT) m_tries++;
                if (m_tries == MT) m_alarm = 1;
                m_step(gel != 0 ? m_dir : 1 - m_dir);
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, queue the expected outputs
    task automatic apply(input int rst, input int st, input int ged, input int gel);
        exp_t e;
        @(negedge clk);
        reset   = rst[0];
        status  = st[2:0];
        gedaald = ged[0];
        gelijk  = gel[0];
        if (rst != 0) begin
            m_active = 0; m_phase = 0; m_spd = 0; m_dir = 1;
            m_calm = 0; m_tries = 0; m_alarm = 0;
        end else if (m_active == 0) begin
            if (st >= SL) begin
                m_active = 1; m_phase = 0; m_spd = SI; m_dir = 1;
            end
        end else if (m_phase == EC) begin
            m_eval(st, ged, gel);
            m_phase = 0;
        end else begin
            m_phase++;
        end
        e.spd  = m_spd;
        e.dir  = m_dir;
        e.rock = m_active;
        e.tick = (m_active != 0 && m_phase == EC) ? 1 : 0;
`ifdef ROCK_ALARM_EN
        e.alm  = m_alarm;
`else
        e.alm  = 0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic hold(input int n, input int st, input int ged, input int gel);
        for (int i = 0; i < n; i++) apply(0, st, ged, gel);
    endtask

    // Monitor: compare DUT outputs shortly after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("speed",     int'(speed),     e.spd);
                chk("direction", int'(direction), e.dir);
                chk("rocking",   int'(rocking),   e.rock);
                chk("eval_tick", int'(eval_tick), e.tick);
                chk("alarm",     int'(alarm),     e.alm);
            end
        end
    end

    initial begin
        int st, ged, gel, rst;
        // Reset, start, then gelijk at every evaluation (speed climbs and reflects)
        apply(1, 0, 0, 0);
        apply(1, 0, 0, 0);
        apply(0, 4, 0, 0);
        hold(5 * (EC + 1) + 2, 5, 0, 1);
        // Improving stress: speed held
        hold(EC + 1, 5, 1, 0);
        // Rising stress: direction flips each evaluation (alarm builds up)
        hold(3 * (EC + 1), 6, 0, 0);
        // Two calm evaluations stop rocking
        hold(2 * (EC + 1) + 2, 0, 0, 0);
        // Restart; one calm evaluation then stress 2 keeps rocking
        apply(0, 4, 0, 0);
        hold(EC + 1, 0, 0, 0);
        hold(2 * (EC + 1), 2, 0, 1);
        // Reset in the middle of a run
        hold(EC, 6, 0, 1);
        apply(1, 6, 0, 1);
        apply(0, 0, 0, 0);
        // Randomized phase with occasional resets
        for (int i = 0; i < 1500; i++) begin
            st  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 7));
            ged = ($urandom_range(0, 2) == 0) ? 1 : 0;
            gel = int'($urandom_range(0, 1));
            rst = ($urandom_range(0, 199) == 0) ? 1 : 0;
            apply(rst, st, ged, gel);
        end
        repeat (2) @(posedge clk);
        #3;
        chk("queue_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rock_strategy_ctrl.md
ROCK_STRATEGY_CTRL -- requirements
Module: rock_strategy_ctrl

Interface
REQ-001 Parameter EVAL_CYCLES, 1000, clock cycles per evaluation window (>=2).
REQ-002 Parameter SPEED_MAX, 7, highest rocking speed code (1..7).
REQ-003 Parameter SPEED_INIT, 3, speed applied on rocking start (1..SPEED_MAX).
REQ-004 Parameter START_LEVEL, 3, minimum status that starts rocking from idle.
REQ-005 Parameter CALM_WINDOWS, 4, consecutive status==0 evaluations before stopping.
REQ-006 Parameter MAX_TRIES, 8, consecutive non-improving evaluations before alarm.
REQ-007 Port clk  in  1  single clock, all logic on rising edge.
REQ-008 Port reset  in  1  synchronous, active-high reset.
REQ-009 Port status  in  3  current stress level, 0 calm .. 7 maximum.
REQ-010 Port gedaald  in  1  stress level decreased versus previous cycle (upstream delta stage).
REQ-011 Port gelijk  in  1  stress level unchanged for two consecutive cycles (upstream delta stage).
REQ-012 Port speed  out  3  rocking speed command, 0 = stopped.
REQ-013 Port direction  out  1  last adjustment direction, 1 = increasing speed.
REQ-014 Port rocking  out  1  high while motor is commanded to rock.
REQ-015 Port eval_tick  out  1  one-cycle pulse during each evaluation cycle.
REQ-016 Port alarm  out  1  sticky "rocking not helping" flag.

Function
REQ-017 FSM states IDLE, RUN, EVAL; all outputs registered.
REQ-018 IDLE: speed=0, rocking=0, window counter=0, calm counter=0; move to RUN when status>=START_LEVEL.
REQ-019 IDLE->RUN transition: next cycle speed=SPEED_INIT, direction=1, rocking=1.
REQ-020 RUN: window counter increments 0..EVAL_CYCLES-1; at EVAL_CYCLES-1 go to EVAL next cycle and clear counter.
REQ-021 EVAL lasts exactly one cycle, eval_tick=1 only there, then returns to RUN unless REQ-026 applies.
REQ-022 EVAL decision priority: status==0 > gedaald > gelijk > otherwise; inputs sampled in EVAL cycle only.
REQ-023 gedaald=1: speed and direction unchanged; calm counter cleared.
REQ-024 gelijk=1 (and not gedaald): step speed by 1 in current direction; at SPEED_MAX going up or at 1 going down, invert direction and step the other way.
REQ-025 Otherwise (stress rose): invert direction, step speed by 1 in new direction, same limit handling as REQ-024.
REQ-026 status==0: speed unchanged, calm counter +1; when it reaches CALM_WINDOWS go to IDLE (speed=0, rocking=0) next cycle; any non-zero status at EVAL clears calm counter.
REQ-027 Speed never leaves 1..SPEED_MAX while rocking=1; never wraps.
REQ-028 Speed/direction updates from EVAL visible on the cycle after eval_tick.
REQ-029 Inputs outside EVAL and IDLE have no effect.

Reset
REQ-030 reset=1 at a rising edge forces IDLE, speed=0, direction=1, rocking=0, eval_tick=0, alarm=0, all counters 0, regardless of state.
REQ-031 Reset has priority over every other event, including an EVAL in the same cycle.

Configuration
REQ-032 Macro ROCK_ALARM_EN compiles in the alarm logic.
REQ-033 With ROCK_ALARM_EN: try counter +1 on each EVAL where gedaald=0 and status!=0, cleared on gedaald=1 or status==0 at EVAL; alarm set when counter reaches MAX_TRIES, counter saturates; alarm cleared only by reset or an EVAL with status==0.
REQ-034 Without ROCK_ALARM_EN: alarm tied to 0, try counter absent; all other behaviour identical.

Verification (bench uses EVAL_CYCLES=4, SPEED_INIT=3, SPEED_MAX=7, CALM_WINDOWS=2, MAX_TRIES=3)
REQ-035 Reset then status=4 -> next cycle rocking=1, speed=3, direction=1; eval_tick first high 5 cycles later.
REQ-036 status=5 held, gelijk=1 at every EVAL -> speed 4,5,6,7,6 with direction flipping to 0 at the 7->6 step.
REQ-037 gedaald=1 at EVAL -> speed and direction unchanged; gedaald=0,gelijk=0 at EVAL with speed=3, direction=1 -> speed=2, direction=0.
REQ-038 status=0 at two consecutive EVALs -> IDLE, speed=0, rocking=0 cycle after second eval_tick; status=0 at one EVAL then 2 -> still rocking.
REQ-039 ROCK_ALARM_EN, three EVALs with gedaald=0, status=6 -> alarm=1 after third eval_tick; build without macro -> alarm stays 0.
REQ-040 reset asserted in RUN with speed=6 -> next cycle speed=0, rocking=0, alarm=0, state IDLE.
